// File: rtl/psum_norm_unit.sv
`default_nettype none
// ======================================================================
// psum_norm_unit : L1 partial-sum normaliser feeding an FWFT output FIFO
// Rev 1.0 - initial release
// ======================================================================
module psum_norm_unit #(
  parameter int COL     = 8,
  parameter int BW_PSUM = 20,
  parameter int FRAC    = 8,
  parameter int DEPTH   = 16,
  parameter int SUM_BW  = BW_PSUM + 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [BW_PSUM*COL-1:0]   in_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [1:0]               mode_i,
  output logic [SUM_BW-1:0]        sum_out_o,
  output logic                     sum_out_valid_o,
  input  logic [SUM_BW-1:0]        sum_in_i,
  input  logic                     sum_in_valid_i,
  output logic [BW_PSUM*COL-1:0]   out_o,
  output logic                     out_valid_o,
  input  logic                     out_rd_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int LANE_W = (COL > 1) ? $clog2(COL) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DIV_W  = SUM_BW + 1;
  localparam int REM_W  = DIV_W + 1;
  localparam int Q_W    = FRAC + 1;
  localparam int BIT_W  = $clog2(FRAC + 1);
  localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(DEPTH);
  localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(COL - 1);
  localparam logic [BIT_W-1:0]  C_LAST_BIT  = BIT_W'(FRAC);

  typedef enum logic [2:0] {IDLE, SUM, WAIT_SUM, DIV, PUSH} state_t;

  state_t                   state_q;
  logic [BW_PSUM*COL-1:0]   vec_q;
  logic                     global_q;
  logic [SUM_BW-1:0]        sum_out_q;
  logic                     sum_out_valid_q;
  logic [DIV_W-1:0]         div_q;
  logic [REM_W-1:0]         rem_q;
  logic [Q_W-1:0]           quo_q;
  logic [LANE_W-1:0]        lane_q;
  logic [BIT_W-1:0]         bit_q;
  logic [BW_PSUM*COL-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         count_q;

  function automatic logic [BW_PSUM-1:0] mag(input logic [BW_PSUM-1:0] x);
    return x[BW_PSUM-1] ? (~x + BW_PSUM'(1)) : x;
  endfunction

  logic [SUM_BW-1:0] sum_d;
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < COL; i++) begin
      sum_d = sum_d + SUM_BW'(mag(vec_q[i*BW_PSUM +: BW_PSUM]));
    end
  end

  // One restoring step: remainder is kept pre-scaled so each cycle is a compare/subtract/shift.
  logic                 ge_d;
  logic [REM_W-1:0]     rem_sub_d;
  logic [Q_W-1:0]       quo_d;
  logic [LANE_W-1:0]    lane_nx_d;
  logic [BW_PSUM-1:0]   cur_x_d;
  logic [BW_PSUM-1:0]   nxt_mag_d;
  logic [BW_PSUM-1:0]   q_ext_d;
  logic [BW_PSUM-1:0]   res_lane_d;

  assign ge_d       = (rem_q >= REM_W'(div_q));
  assign rem_sub_d  = ge_d ? (rem_q - REM_W'(div_q)) : rem_q;
  assign quo_d      = {quo_q[Q_W-2:0], ge_d};
  assign lane_nx_d  = lane_q + LANE_W'(1);
  assign cur_x_d    = vec_q[lane_q*BW_PSUM +: BW_PSUM];
  assign nxt_mag_d  = mag(vec_q[lane_nx_d*BW_PSUM +: BW_PSUM]);
  assign q_ext_d    = (div_q == '0) ? '0 : BW_PSUM'(quo_d);
  assign res_lane_d = cur_x_d[BW_PSUM-1] ? (~q_ext_d + BW_PSUM'(1)) : q_ext_d;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q         <= IDLE;
      vec_q           <= '0;
      global_q        <= 1'b0;
      sum_out_q       <= '0;
      sum_out_valid_q <= 1'b0;
      div_q           <= '0;
      rem_q           <= '0;
      quo_q           <= '0;
      lane_q          <= '0;
      bit_q           <= '0;
    end else begin
      sum_out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_o) begin
            vec_q    <= in_i;
            global_q <= (mode_i == 2'b10);
            state_q  <= (mode_i == 2'b01 || mode_i == 2'b10) ? SUM : PUSH;
          end
        end
        SUM: begin
          sum_out_q       <= sum_d;
          sum_out_valid_q <= 1'b1;
          div_q           <= DIV_W'(sum_d);
          rem_q           <= REM_W'(mag(vec_q[BW_PSUM-1:0]));
          quo_q           <= '0;
          lane_q          <= '0;
          bit_q           <= '0;
          state_q         <= global_q ? WAIT_SUM : DIV;
        end
        WAIT_SUM: begin
          if (sum_in_valid_i) begin
            div_q   <= DIV_W'(sum_out_q) + DIV_W'(sum_in_i);
            state_q <= DIV;
          end
        end
        DIV: begin
          if (bit_q == C_LAST_BIT) begin
            // Lane result overwrites its own raw value; later lanes are still untouched.
            vec_q[lane_q*BW_PSUM +: BW_PSUM] <= res_lane_d;
            if (lane_q == C_LAST_LANE) begin
              state_q <= PUSH;
            end else begin
              lane_q <= lane_nx_d;
              rem_q  <= REM_W'(nxt_mag_d);
              quo_q  <= '0;
              bit_q  <= '0;
            end
          end else begin
            rem_q <= rem_sub_d << 1;
            quo_q <= quo_d;
            bit_q <= bit_q + BIT_W'(1);
          end
        end
        PUSH:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic push_d;
  logic pop_d;
  assign push_d = (state_q == PUSH);
  assign pop_d  = out_rd_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= vec_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_d) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_d)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_d && !pop_d)      count_q <= count_q + CNT_W'(1);
      else if (!push_d && pop_d) count_q <= count_q - CNT_W'(1);
    end
  end

  assign in_ready_o      = reset_i && (state_q == IDLE) && (count_q < C_DEPTH);
  assign sum_out_o       = sum_out_q;
  assign sum_out_valid_o = sum_out_valid_q;
  assign out_valid_o     = (count_q != '0);
  assign out_o           = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_norm_unit.sv
`default_nettype none
// ======================================================================
// tb_psum_norm_unit : randomized + directed bench with arithmetic model
// Rev 1.0 - initial release
// ======================================================================
module tb_psum_norm_unit;
  localparam int COL  = 8;
  localparam int BW   = 20;
  localparam int FRAC = 8;
  localparam int VW   = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [VW-1:0] in_v = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    mode = 2'b00;
  logic [23:0]   sum_out;
  logic          sum_out_valid;
  logic [23:0]   sum_in = '0;
  logic          sum_in_valid = 1'b0;
  logic [VW-1:0] out_v;
  logic          out_valid;
  logic          out_rd = 1'b0;
  logic [4:0]    count;

  int total = 0;
  int bad   = 0;
  int lv[8];
  logic [VW-1:0] exp_q[$];

  psum_norm_unit dut (
    .clk_i(clk), .reset_i(reset),
    .in_i(in_v), .in_valid_i(in_valid), .in_ready_o(in_ready), .mode_i(mode),
    .sum_out_o(sum_out), .sum_out_valid_o(sum_out_valid),
    .sum_in_i(sum_in), .sum_in_valid_i(sum_in_valid),
    .out_o(out_v), .out_valid_o(out_valid), .out_rd_i(out_rd), .count_o(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] pack_lv();
    logic [VW-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = BW'(lv[i]);
    return v;
  endfunction

  function automatic int rnd_lane();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return int'($urandom_range(0, 2000)) - 1000;
      2:       return int'($urandom_range(0, 1048575)) - 524288;
      default: return ($urandom_range(0, 1) == 1) ? -524288 : 524287;
    endcase
  endfunction

  // Reference: plain integer L1 normalisation of each lane.
  function automatic void model(input logic [VW-1:0] v, input logic [1:0] m, input longint sin,
                                output logic [VW-1:0] y, output longint s);
    longint x[COL];
    longint d, q, a;
    s = 0;
    for (int i = 0; i < COL; i++) begin
      x[i] = longint'($signed(v[i*BW +: BW]));
      s += (x[i] < 0) ? -x[i] : x[i];
    end
    d = (m == 2'b10) ? s + sin : s;
    for (int i = 0; i < COL; i++) begin
      if (m == 2'b01 || m == 2'b10) begin
        a = (x[i] < 0) ? -x[i] : x[i];
        q = (d == 0) ? 0 : (a * (64'sd1 <<< FRAC)) / d;
        y[i*BW +: BW] = BW'((x[i] < 0) ? -q : q);
      end else begin
        y[i*BW +: BW] = v[i*BW +: BW];
      end
    end
  endfunction

  task automatic send(input logic [VW-1:0] v, input logic [1:0] m);
    int guard = 0;
    while (!in_ready && guard < 500) begin
      step();
      guard++;
    end
    if (!in_ready) chk("send_ready_timeout", {159'd0, in_ready}, 1);
    in_v = v;
    mode = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // One vector end to end: latency, data, sum_out pulse, then pop it.
  task automatic xact(input logic [VW-1:0] v, input logic [1:0] m, input longint sin,
                      input int dly, input string tag);
    logic [VW-1:0] ey;
    longint es;
    int lat, exp_lat, sov_cyc, sov_cnt;
    logic [23:0] sov_val;
    bit norm, glob;
    model(v, m, sin, ey, es);
    norm = (m == 2'b01 || m == 2'b10);
    glob = (m == 2'b10);
    exp_lat = !norm ? 2 : 3 + COL * (FRAC + 1) + (glob ? dly + 1 : 0);
    sum_in = 24'(sin);
    sum_in_valid = 1'b0;
    send(v, m);
    lat = 1;
    sov_cyc = -1;
    sov_cnt = 0;
    sov_val = '0;
    while (!out_valid && lat < 400) begin
      sum_in_valid = glob && (lat >= 2 + dly);
      if (sum_out_valid) begin
        sov_cyc = lat;
        sov_val = sum_out;
        sov_cnt++;
      end
      step();
      lat++;
    end
    sum_in_valid = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_data"}, out_v, ey);
    if (norm) begin
      chk({tag, "_sumvalid_cycle"}, sov_cyc, 2);
      chk({tag, "_sum"}, sov_val, 24'(es));
    end else begin
      chk({tag, "_sumvalid_pulses"}, sov_cnt, 0);
    end
    out_rd = 1'b1;
    step();
    out_rd = 1'b0;
    chk({tag, "_count_after_pop"}, count, 0);
  endtask

  initial begin
    logic [VW-1:0] v, v17;
    reset = 1'b0;
    repeat (3) step();
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum_out", sum_out, 0);
    chk("rst_sum_out_valid", sum_out_valid, 0);
    chk("rst_in_ready_low", in_ready, 0);
    chk("rst_out", out_v, 0);
    reset = 1'b1;
    step();
    chk("rst_in_ready_release", in_ready, 1);

    lv = '{5, -3, 0, 7, 1, 1, 1, -100};
    xact(pack_lv(), 2'b00, 0, 0, "pass");
    lv = '{1, -1, 2, 0, 0, 0, 0, 4};
    xact(pack_lv(), 2'b01, 0, 0, "local");
    lv = '{1, 1, 1, 1, 1, 1, 1, 1};
    xact(pack_lv(), 2'b10, 8, 0, "global");
    xact(pack_lv(), 2'b10, 8, 10, "global_dly10");
    lv = '{0, 0, 0, 0, 0, 0, 0, 0};
    xact(pack_lv(), 2'b01, 0, 0, "zero");
    lv = '{-524288, 0, 0, 0, 0, 0, 0, 0};
    xact(pack_lv(), 2'b01, 0, 0, "extreme");
    lv = '{9, -9, 300, -77, 0, 12, 524287, -2};
    xact(pack_lv(), 2'b11, 0, 0, "mode11");

    for (int n = 0; n < 8; n++) begin
      for (int j = 0; j < COL; j++) lv[j] = rnd_lane();
      xact(pack_lv(), 2'($urandom_range(0, 3)), longint'($urandom_range(0, 16777215)),
           int'($urandom_range(0, 4)), "rand");
    end

    // FIFO fill, back-pressure, single pop and drain across pointer wrap.
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < COL; j++) lv[j] = rnd_lane();
      v = pack_lv();
      send(v, 2'b00);
      exp_q.push_back(v);
    end
    step();
    chk("full_count", count, 16);
    chk("full_in_ready", in_ready, 0);
    for (int j = 0; j < COL; j++) lv[j] = rnd_lane();
    v17 = pack_lv();
    in_v = v17;
    mode = 2'b00;
    in_valid = 1'b1;
    repeat (3) begin
      step();
      chk("held_count", count, 16);
    end
    chk("head_before_pop", out_v, exp_q[0]);
    out_rd = 1'b1;
    step();
    out_rd = 1'b0;
    void'(exp_q.pop_front());
    chk("in_ready_after_pop", in_ready, 1);
    step();
    in_valid = 1'b0;
    exp_q.push_back(v17);
    step();
    chk("refill_count", count, 16);
    for (int k = 0; k < 16; k++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_v, exp_q.pop_front());
      out_rd = 1'b1;
      step();
      out_rd = 1'b0;
    end
    chk("drained_out_valid", out_valid, 0);
    chk("drained_out", out_v, 0);
    chk("drained_count", count, 0);

    // Reset while a local-norm vector is in DIV with three entries queued.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < COL; j++) lv[j] = rnd_lane();
      send(pack_lv(), 2'b00);
    end
    lv = '{100, -50, 25, 0, 3, 0, 0, 7};
    send(pack_lv(), 2'b01);
    repeat (10) step();
    chk("pre_reset_count", count, 3);
    reset = 1'b0;
    step();
    chk("midrst_count", count, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum_out", sum_out, 0);
    chk("midrst_in_ready", in_ready, 0);
    reset = 1'b1;
    step();
    chk("postrst_in_ready", in_ready, 1);
    lv = '{-1, 2, -3, 4, -5, 6, -7, 8};
    v = pack_lv();
    send(v, 2'b00);
    chk("postrst_T1_out_valid", out_valid, 0);
    step();
    chk("postrst_T2_out_valid", out_valid, 1);
    chk("postrst_data", out_v, v);
    chk("postrst_count", count, 1);
    out_rd = 1'b1;
    step();
    out_rd = 1'b0;
    chk("postrst_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psum_norm_unit.md
# psum_norm_unit

Parametrised partial-sum normalisation unit, the successor to the fixed 8-lane normaliser plus its separate 16-deep output FIFO in the attention core. It accepts one vector of `col` signed partial sums at a time. In normalise modes it divides each lane by the L1 norm, either the local norm or a global one that includes the partner core's sum via the `sum_out`/`sum_in` exchange. Results are queued in an internal FIFO of configurable depth with ready/valid flow control. It sits between the psum SRAM read port and the psum SRAM write-back mux.

## Interface
- `col`, 8: lane count.
- `bw_psum`, 20: signed lane width.
- `frac`, 8: fraction bits of the normalised result; legal range 1..`bw_psum`-2.
- `depth`, 16: output FIFO entries, power of two, ≥2.
- `sum_bw`, `bw_psum`+4: width of the sum exchange.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low; sampled at `clk` rising edge.
- `in` in `bw_psum*col`: input vector, lane i at bits [i*bw_psum +: bw_psum], two's complement.
- `in_valid` in 1: input vector present.
- `in_ready` out 1: unit can accept a vector.
- `mode` in 2: sampled at accept. 00 = pass, 01 = local norm, 10 = global norm, 11 = treated as pass.
- `sum_out` out `sum_bw`: local L1 sum of the last normalise-mode vector.
- `sum_out_valid` out 1: one-cycle pulse when `sum_out` updates.
- `sum_in` in `sum_bw`: partner core's L1 sum.
- `sum_in_valid` in 1: `sum_in` is valid; level-sampled.
- `out` out `bw_psum*col`: FIFO head (first-word fall-through).
- `out_valid` out 1: FIFO not empty.
- `out_rd` in 1: pop the head.
- `count` out `$clog2(depth)+1`: FIFO occupancy.

## Operation
- **FSM states:** IDLE, SUM, WAIT_SUM, DIV, PUSH.
- **Accept:** occurs when `in_valid` && `in_ready`.
  - `in_ready` = (state==IDLE) && (`count`<`depth`).
  - On accept, `in` and `mode` are registered.
  - Transition to PUSH for pass mode, otherwise to SUM.
- **SUM:**
  - S = Σ|x_i|, computed with zero-extended magnitudes; |−2^(bw_psum−1)| = 2^(bw_psum−1), no overflow.
  - S is registered into `sum_out`; `sum_out_valid` pulses the following cycle.
  - Next state is DIV for mode 01, WAIT_SUM for mode 10.
- **WAIT_SUM:**
  - Stays in this state until `sum_in_valid`=1 is sampled.
  - On that cycle, D = S + `sum_in` is captured (width `sum_bw`+1), then transition to DIV.
  - In local mode D = S.
- **DIV:**
  - Lanes are processed 0..col−1, one restoring-divider quotient bit per cycle, `frac`+1 cycles per lane.
  - q_i = floor(|x_i|·2^frac / D). Since q_i ≤ 2^frac, no saturation is needed.
  - Result lane = +q_i if x_i≥0, else −q_i, sign-extended to `bw_psum`.
  - If D==0, all lanes are 0; cycle count is unchanged.
- **PUSH:** writes the result vector (or the raw vector in pass mode) into the FIFO, then returns to IDLE.
- **FIFO:**
  - Circular buffer; read and write pointers wrap modulo `depth`.
  - Pop when `out_rd` && `out_valid`; `out_rd` while empty is ignored.
  - Simultaneous push and pop leaves `count` unchanged.
  - Overflow is impossible: accept requires a free slot, and only one vector is ever in flight.
- **Reset (`reset`=0 at an edge):**
  - State goes to IDLE, FIFO is emptied, and any in-flight vector is discarded.
  - Output values after reset: `count`=0, `out_valid`=0, `sum_out`=0, `sum_out_valid`=0.
  - `in_ready`=0 while `reset` is low and 1 in the first cycle after release.
  - `out` reads as 0 when the FIFO is empty.

## Timing
- Accept at edge T (end of cycle T).
- **Pass mode:** PUSH in cycle T+1; `out_valid` rises in cycle T+2.
- **Local mode:**
  - SUM in cycle T+1; `sum_out`/`sum_out_valid` visible in cycle T+2.
  - DIV in cycles T+2 .. T+1+col·(frac+1).
  - PUSH in cycle T+2+col·(frac+1); `out_valid` rises in cycle T+3+col·(frac+1), which is T+75 at defaults.
- **Global mode:** adds W ≥ 1 WAIT_SUM cycles, where W = cycles until `sum_in_valid` is seen. At defaults, if `sum_in_valid` is already high, `out_valid` rises at T+76.
- `in_ready` is high again in the cycle after PUSH if `count`<`depth`. Maximum pass-mode throughput is one vector per 2 cycles.
- Pop at edge P: `count` decrements and the next head is visible in cycle P+1.

## Test plan
- **Pass mode:** vector lanes 0..7 = 5,−3,0,7,1,1,1,−100 → `out` equals the input exactly; `out_valid` at T+2; `sum_out_valid` never pulses.
- **Local norm:** lanes 1,−1,2,0,0,0,0,4 → `sum_out`=8; `out` = 32,−32,64,0,0,0,0,128; `out_valid` at T+75.
- **Global norm:** all lanes 1 with `sum_in`=8 held from cycle T+2 → `sum_out`=8, all lanes 16. Then repeat with `sum_in_valid` delayed by 10 cycles → identical data, `out_valid` 10 cycles later.
- **Zero / extreme inputs:**
  - All lanes 0 in mode 01 → all-zero output, `sum_out`=0, normal latency.
  - Lane 0 = −524288, others 0 → lane 0 = −256.
- **FIFO limits:**
  - 16 pass vectors with `out_rd`=0 → `count`=16, `in_ready`=0, `in_valid` held but not accepted.
  - One pop → `in_ready`=1 next cycle.
  - Drain 16 entries → data in order across pointer wrap, then `out_valid`=0.
- **Reset mid-operation:** `reset` low during DIV of a local-norm vector with 3 FIFO entries queued → next cycle `count`=0, `out_valid`=0, `sum_out`=0. A new pass vector after release emerges at T+2 with no stale data.
